// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : per-line pending-load counters driving the decode stall,
//                  with same-cycle writeback bypass and a drain handshake.
// Optional: define SCB_PERF_EN to add the perf_stall_cnt port and counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NLINE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [3:0]       iss_rs1,
    input  logic [3:0]       iss_rs2,
    input  logic             iss_rs1_en,
    input  logic             iss_rs2_en,
    input  logic [3:0]       iss_rd,
    input  logic             iss_rd_en,
    input  logic             iss_load,
    input  logic             n_stall,
    input  logic             flush,
    input  logic             ld_done,
    input  logic [3:0]       ld_rd,
    input  logic             drain_req,
    output logic             scb_nstall,
    output logic             drain_ack,
    output logic [NLINE-1:0] scb_busy,
`ifdef SCB_PERF_EN
    output logic             scb_err,
    output logic [31:0]      perf_stall_cnt
`else
    output logic             scb_err
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [CNT_W-1:0] cnt_q [NLINE];
    logic [CNT_W-1:0] cnt_d [NLINE];
    logic [0:0]       state_q, state_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic [NLINE-1:0] eff_busy;
    logic             hazard, fire, inc, dec, same_line, all_zero_d;

    // A line whose last outstanding load returns this cycle is free: decode forwards the data.
    always_comb begin
        for (int l = 0; l < NLINE; l++) begin
            eff_busy[l] = (cnt_q[l] != '0) &&
                          !(ld_done && (ld_rd == 4'(l)) && (cnt_q[l] == C_CNT_ONE));
            scb_busy[l] = (cnt_q[l] != '0);
        end
    end

    // Loads to a busy line only stall on saturation; memory returns in order.
    assign hazard = (iss_rs1_en & eff_busy[iss_rs1])
                  | (iss_rs2_en & eff_busy[iss_rs2])
                  | (iss_rd_en & ~iss_load & eff_busy[iss_rd])
                  | (iss_rd_en &  iss_load & (cnt_q[iss_rd] == C_CNT_MAX));

    assign fire      = iss_valid & n_stall & scb_nstall & ~flush;
    assign inc       = fire & iss_load & iss_rd_en;
    assign dec       = ld_done;
    assign same_line = inc & dec & (iss_rd == ld_rd);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc && !same_line) begin
            cnt_d[iss_rd] = cnt_q[iss_rd] + C_CNT_ONE;
        end
        if (dec && !same_line) begin
            if (cnt_q[ld_rd] == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d[ld_rd] = cnt_q[ld_rd] - C_CNT_ONE;
            end
        end
        all_zero_d = 1'b1;
        for (int l = 0; l < NLINE; l++) begin
            if (cnt_d[l] != '0) begin
                all_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < NLINE; l++) begin
                cnt_q[l] <= '0;
            end
            err_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            ack_q <= ack_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (drain_req)  state_d = S_DRAIN;
            S_DRAIN: if (all_zero_d) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scb_nstall = (state_q == S_IDLE) & ~(iss_valid & hazard);
        ack_d      = (state_q == S_DRAIN) & all_zero_d;
    end

    assign drain_ack = ack_q;
    assign scb_err   = err_q;

`ifdef SCB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (iss_valid & n_stall & ~scb_nstall & ~flush) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

`default_nettype wire
